hazard_scoreboard: RTL

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

---
 rtl/hazard_scoreboard.sv | 110 +++++++++++
 1 files changed

// File: rtl/hazard_scoreboard.sv
// Decode-stage hazard scoreboard: per-register result-latency counters for
// RAW interlock, plus an outstanding-store counter that blocks loads while
// stores are in flight and blocks stores when the store queue is full.
module hazard_scoreboard #(
  parameter int NUM_REGS   = 16,
  parameter int REG_AW     = 4,
  parameter int LATENCY    = 4,
  parameter int CNT_W      = 3,
  parameter int MAX_STORES = 4,
  parameter int SW         = $clog2(MAX_STORES + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                d_valid,
  input  logic                d_ra_use,
  input  logic                d_rb_use,
  input  logic [REG_AW-1:0]   d_ra,
  input  logic [REG_AW-1:0]   d_rb,
  input  logic                d_rt_use,
  input  logic [REG_AW-1:0]   d_rt,
  input  logic                d_is_store,
  input  logic                d_is_load,
  input  logic                flush,
  input  logic                w_store_done,
  output logic                d_stall,
  output logic                d_issue,
  output logic [NUM_REGS-1:0] busy_mask,
  output logic [SW-1:0]       stores_pending,
  output logic                err_underflow
);

  localparam int unsigned NREGS = NUM_REGS;

  // The issue cycle itself is the first latency cycle, so the counter holds
  // the remaining stall cycles: a back-to-back dependent stalls LATENCY-1
  // cycles and LATENCY=1 never stalls.
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(LATENCY - 1);

  logic [CNT_W-1:0] cnt_q [NUM_REGS];
  logic [CNT_W-1:0] cnt_d [NUM_REGS];
  logic [SW-1:0]    stores_q, stores_d;
  logic             err_q, err_d;

  logic raw_a, raw_b, ld_block, st_full;
  logic st_inc, st_dec;

  // Hazard detection against the current (pre-update) counters; indices
  // outside the tracked range never match, so they read as idle.
  always_comb begin
    raw_a = 1'b0;
    raw_b = 1'b0;
    for (int unsigned i = 0; i < NREGS; i++) begin
      if (d_ra_use && d_ra == REG_AW'(i) && cnt_q[i] != '0) raw_a = 1'b1;
      if (d_rb_use && d_rb == REG_AW'(i) && cnt_q[i] != '0) raw_b = 1'b1;
    end
    ld_block = d_is_load && (stores_q != '0);
    st_full  = d_is_store && (stores_q == SW'(MAX_STORES));
    d_stall  = d_valid && (raw_a || raw_b || ld_block || st_full);
    d_issue  = d_valid && !d_stall && !flush;
  end

  // Counter next state: reload on issuing write, else count down to zero.
  always_comb begin
    for (int unsigned i = 0; i < NREGS; i++) begin
      cnt_d[i] = cnt_q[i];
      if (d_issue && d_rt_use && d_rt == REG_AW'(i)) begin
        cnt_d[i] = LOAD_VAL;
      end else if (cnt_q[i] != '0) begin
        cnt_d[i] = cnt_q[i] - CNT_W'(1);
      end
    end
  end

  // Outstanding-store count; a done with nothing pending flags underflow.
  always_comb begin
    st_inc   = d_issue && d_is_store;
    st_dec   = w_store_done;
    stores_d = stores_q;
    err_d    = err_q;
    case ({st_inc, st_dec})
      2'b10: stores_d = stores_q + SW'(1);
      2'b01: begin
        if (stores_q == '0) err_d = 1'b1;
        else                stores_d = stores_q - SW'(1);
      end
      default: stores_d = stores_q;
    endcase
  end

  // State registers with synchronous active-low reset overriding all activity.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREGS; i++) cnt_q[i] <= '0;
      stores_q <= '0;
      err_q    <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < NREGS; i++) cnt_q[i] <= cnt_d[i];
      stores_q <= stores_d;
      err_q    <= err_d;
    end
  end

  // Registered views of the state.
  always_comb begin
    for (int unsigned i = 0; i < NREGS; i++) busy_mask[i] = (cnt_q[i] != '0);
    stores_pending = stores_q;
    err_underflow  = err_q;
  end

endmodule
